// File: rtl/subbytes_seq.sv
// -----------------------------------------------------------------------------
// subbytes_seq
//   Sequential AES SubBytes / InvSubBytes over a 128-bit state. LANES bytes
//   are substituted per cycle through a shared bank of S-box and inverse
//   S-box lanes, so a block takes STEPS = 16/LANES cycles in RUN.
//
// Ports
//   CLK        in   1    clock, rising edge
//   RST        in   1    asynchronous active-high reset
//   IN_VALID   in   1    IN / INV valid
//   IN_READY   out  1    block accepts an input (IDLE only)
//   IN         in   128  state, byte 0 = IN[127:120], byte 15 = IN[7:0]
//   INV        in   1    0 = forward S-box, 1 = inverse S-box
//   OUT_VALID  out  1    OUT holds a completed result (DONE)
//   OUT_READY  in   1    downstream accepts OUT
//   OUT        out  128  substituted state, same byte order as IN
//   BUSY       out  1    high in RUN and DONE
// -----------------------------------------------------------------------------

// Forward AES S-box, one byte. Table byte 0 sits in the MSBs, so entry a
// lives at bit offset 8*(255-a) = {~a, 3'b000}.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

// Inverse AES S-box, one byte. Same table layout as aes_sbox.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

module subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN,
    input  logic         INV,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT,
    output logic         BUSY
);
    localparam int STEPS = 16 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         step;
    logic                  mode;
    logic [127:0]          work;
    logic [127:0]          work_next;
    logic [127:0]          out_reg;

    logic [3:0]            lane_byte [LANES];
    logic [LANES-1:0][7:0] lane_in;
    logic [LANES-1:0][7:0] fwd_out;
    logic [LANES-1:0][7:0] inv_out;

    // Byte index handled by each lane in the current chunk, and the byte it
    // reads. Byte b sits at bit offset 8*(15-b) = {~b, 3'b000}.
    // NOTE: every always_comb output gets a value on every path (defaults
    // first, then overrides) so no latches are inferred.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_byte[l] = 4'(int'(step) * LANES + l);
            lane_in[l]   = work[{~lane_byte[l], 3'b000} +: 8];
        end
    end

    // One forward and one inverse S-box per lane, shared by all chunks.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox     u_fwd (.a(lane_in[g]), .y(fwd_out[g]));
        aes_inv_sbox u_inv (.a(lane_in[g]), .y(inv_out[g]));
    end

    // Working register with the current chunk substituted; bytes outside the
    // chunk pass through untouched.
    always_comb begin
        work_next = work;
        for (int l = 0; l < LANES; l++) begin
            work_next[{~lane_byte[l], 3'b000} +: 8] = mode ? inv_out[l] : fwd_out[l];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            step    <= '0;
            mode    <= 1'b0;
            work    <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        work  <= IN;
                        mode  <= INV;
                        step  <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    work <= work_next;
                    // The counter stops at the last chunk; only a new accept
                    // brings it back to zero.
                    if (step == LAST_STEP) begin
                        out_reg <= work_next;
                        state   <= S_DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // out_reg is loaded with the finished working register, so it equals the
    // working register in DONE and keeps the last result afterwards.
    assign IN_READY  = (state == S_IDLE);
    assign OUT_VALID = (state == S_DONE);
    assign BUSY      = (state != S_IDLE);
    assign OUT       = out_reg;
endmodule

// File: tb/tb_subbytes_seq.sv
// -----------------------------------------------------------------------------
// tb_subbytes_seq
//   Directed bench for subbytes_seq. Five instances (LANES = 1, 2, 4, 8, 16)
//   share clock, reset and the IN/INV bus, each with its own handshake.
//   Expected values are known AES SubBytes results.
// -----------------------------------------------------------------------------
module tb_subbytes_seq;
    localparam logic [127:0] VEC_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_B  = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] VEC_63 = {16{8'h63}};

    logic                 CLK;
    logic                 RST;
    logic [127:0]         in_data;
    logic                 in_inv;
    logic [4:0]           in_valid;
    logic [4:0]           out_ready;
    wire  [4:0]           in_ready;
    wire  [4:0]           out_valid;
    wire  [4:0]           busy;
    wire  [4:0][127:0]    out_data;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        subbytes_seq #(.LANES(1 << g)) dut (
            .CLK       (CLK),
            .RST       (RST),
            .IN_VALID  (in_valid[g]),
            .IN_READY  (in_ready[g]),
            .IN        (in_data),
            .INV       (in_inv),
            .OUT_VALID (out_valid[g]),
            .OUT_READY (out_ready[g]),
            .OUT       (out_data[g]),
            .BUSY      (busy[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one block to instance idx once it is idle, then scrambles the
    // shared input bus so a design that re-samples it would be caught.
    task automatic accept(input logic [2:0] idx, input logic [127:0] data, input logic inv);
        int n;
        n = 0;
        @(negedge CLK);
        while (in_ready[idx] !== 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("idle_before_accept_l%0d", 1 << idx), 128'(in_ready[idx]), 128'd1);
        in_data       = data;
        in_inv        = inv;
        in_valid[idx] = 1'b1;
        @(posedge CLK);
        #1;
        in_valid[idx] = 1'b0;
        in_data       = ~data;
        in_inv        = ~inv;
    endtask

    task automatic wait_out(input logic [2:0] idx, output int lat);
        lat = 0;
        while (out_valid[idx] !== 1'b1 && lat < 64) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic run_block(input logic [2:0] idx, input logic [127:0] data,
                             input logic inv, input logic [127:0] exp);
        int lat;
        accept(idx, data, inv);
        check($sformatf("ready_busy_in_run_l%0d", 1 << idx),
              128'({in_ready[idx], busy[idx]}), 128'b01);
        wait_out(idx, lat);
        check($sformatf("latency_l%0d", 1 << idx), 128'(lat), 128'(16 >> idx));
        check($sformatf("out_l%0d_inv%0d", 1 << idx, inv), out_data[idx], exp);
    endtask

    logic [2:0]   sel [4];
    logic [127:0] bb_in  [4];
    logic [127:0] bb_exp [4];
    logic         bb_inv [4];

    initial begin
        int seen;
        int nb;
        int ob;
        int acc_cyc [4];
        logic took;

        sel    = '{3'd0, 3'd1, 3'd3, 3'd4};
        bb_in  = '{VEC_A, VEC_B, 128'h0, VEC_63};
        bb_exp = '{VEC_B, VEC_A, VEC_63, 128'h0};
        bb_inv = '{1'b0, 1'b1, 1'b0, 1'b1};

        RST       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        in_data   = '0;
        in_inv    = 1'b0;

        // Outputs while reset is held.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'h1f);
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst_out_l%0d", 1 << i), out_data[3'(i)], 128'h0);
        end

        // Forward vector on LANES=4; its accept lands on the first rising
        // edge with RST low. OUT_READY is held low to stall in DONE.
        RST          = 1'b0;
        out_ready[2] = 1'b0;
        run_block(3'd2, VEC_A, 1'b0, VEC_B);

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            in_valid[2] = (i % 2 == 0);
            in_data     = {$urandom, $urandom, $urandom, $urandom};
            in_inv      = ~in_inv;
            @(posedge CLK);
            #1;
            check("stall_valid_ready_busy",
                  128'({out_valid[2], in_ready[2], busy[2]}), 128'b101);
            check("stall_out", out_data[2], VEC_B);
        end
        @(negedge CLK);
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        @(posedge CLK);
        #1;
        check("release_to_idle", 128'({out_valid[2], in_ready[2], busy[2]}), 128'b010);
        check("release_out_kept", out_data[2], VEC_B);
        @(posedge CLK);
        #1;
        check("no_queued_input", 128'(busy[2]), 128'd0);

        // Inverse on LANES=4.
        run_block(3'd2, VEC_B, 1'b1, VEC_A);

        // All-zero state on the other lane counts.
        for (int i = 0; i < 4; i++) begin
            run_block(sel[i], 128'h0, 1'b0, VEC_63);
        end

        // Inverse through the narrowest and widest datapaths.
        run_block(3'd0, VEC_B, 1'b1, VEC_A);
        run_block(3'd4, VEC_B, 1'b1, VEC_A);

        // Reset two cycles into a LANES=4 block aborts it.
        accept(3'd2, VEC_A, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check("abort_still_running", 128'(busy[2]), 128'd1);
        RST = 1'b1;
        #1;
        check("abort_out_zero", out_data[2], 128'h0);
        check("abort_ready_valid", 128'({in_ready[2], out_valid[2]}), 128'b10);
        @(posedge CLK);
        #1;
        RST  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid[2] === 1'b1) seen++;
        end
        check("abort_no_result", 128'(seen), 128'd0);
        check("abort_out_stays_zero", out_data[2], 128'h0);

        // Back-to-back blocks on LANES=4 with INV toggling per block.
        out_ready[2] = 1'b1;
        nb = 0;
        ob = 0;
        for (int cyc = 0; cyc < 60 && ob < 4; cyc++) begin
            @(negedge CLK);
            if (nb < 4) begin
                in_valid[2] = 1'b1;
                in_data     = bb_in[nb];
                in_inv      = bb_inv[nb];
            end else begin
                in_valid[2] = 1'b0;
                in_data     = '0;
            end
            took = in_ready[2] && in_valid[2];
            @(posedge CLK);
            #1;
            if (took) begin
                acc_cyc[nb] = cyc;
                if (nb > 0) begin
                    check($sformatf("b2b_spacing_%0d", nb), 128'(cyc - acc_cyc[nb-1]), 128'd6);
                end
                nb++;
            end
            if (out_valid[2] === 1'b1 && ob < 4) begin
                check($sformatf("b2b_out_%0d", ob), out_data[2], bb_exp[ob]);
                check($sformatf("b2b_latency_%0d", ob), 128'(cyc - acc_cyc[ob]), 128'd4);
                ob++;
            end
        end
        in_valid[2] = 1'b0;
        check("b2b_result_count", 128'(ob), 128'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/subbytes_seq.md
SUBBYTES_SEQ -- requirements
Module: subbytes_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, giving the number of S-box lanes per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have derived localparam STEPS = 16/LANES, giving the processing cycles per block.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port IN_VALID, input, 1 bit: IN and INV are valid.
REQ-006 SHALL have port IN_READY, output, 1 bit: block can accept an input.
REQ-007 SHALL have port IN, input, 128 bits: AES state; byte 0 is IN[127:120], byte 15 is IN[7:0].
REQ-008 SHALL have port INV, input, 1 bit: 0 selects forward SubBytes (Sbox), 1 selects inverse (InvSbox).
REQ-009 SHALL have port OUT_VALID, output, 1 bit: OUT holds a completed result.
REQ-010 SHALL have port OUT_READY, input, 1 bit: downstream accepts OUT.
REQ-011 SHALL have port OUT, output, 128 bits: substituted state, using the same byte order as IN.
REQ-012 SHALL have port BUSY, output, 1 bit: high in RUN and in DONE.

Function
REQ-013 SHALL instantiate exactly LANES Sbox and LANES InvSbox instances, shared across steps; there SHALL be no 16-wide replication when LANES<16.
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: IN_READY=1, OUT_VALID=0; IN_VALID=1 SHALL be an accept, which captures IN into the working register and INV into a mode register, clears the step counter, and moves to RUN.
REQ-016 RUN: IN_READY=0; each cycle SHALL replace the bytes of chunk k (bytes k*LANES .. k*LANES+LANES-1) with their S-box or InvSbox image, selected by the captured mode, then increment k.
REQ-017 RUN SHALL move to DONE on the cycle that processes chunk STEPS-1.
REQ-018 Latency: OUT_VALID SHALL rise exactly STEPS cycles after the accept edge.
REQ-019 DONE: OUT_VALID=1 and OUT = the working register; OUT SHALL hold stable while OUT_READY=0.
REQ-020 DONE with OUT_READY=1 SHALL go to IDLE on the next edge; OUT SHALL keep its last value, but OUT_VALID SHALL drop.
REQ-021 IN_READY SHALL be 0 in DONE; there SHALL be no same-cycle output/accept overlap, so minimum throughput is one block per STEPS+2 cycles.
REQ-022 INV and IN changes after the accept SHALL NOT affect the block in flight.
REQ-023 IN_VALID asserted while not in IDLE SHALL be ignored; no input is queued.
REQ-024 The step counter SHALL be $clog2(STEPS) bits wide, at least 1 bit; it SHALL wrap to 0 only via an accept, and never count past STEPS-1.
REQ-025 The LANES=16 case SHALL make RUN last a single cycle, so OUT_VALID rises 1 cycle after the accept.
REQ-026 Bytes not yet processed SHALL be left unmodified in the working register during RUN.

Reset
REQ-027 RST=1 SHALL, asynchronously, force state to IDLE, counter to 0, mode to 0, working register to 0, and OUT to 128'h0.
REQ-028 The reset values of the outputs SHALL be OUT_VALID=0, IN_READY=1, BUSY=0 for as long as RST is held.
REQ-029 RST asserted mid-RUN or in DONE SHALL abort the block; no OUT_VALID SHALL follow for it.
REQ-030 The first accept after RST deasserts SHALL be possible on the first rising edge with RST low.

Verification
REQ-031 LANES=4, INV=0, IN=00112233445566778899aabbccddeeff -> OUT=638293c31bfc33f5c4eeacea4bc12816, with OUT_VALID exactly 4 cycles after the accept.
REQ-032 LANES=4, INV=1, IN=638293c31bfc33f5c4eeacea4bc12816 -> OUT=00112233445566778899aabbccddeeff.
REQ-033 For LANES in {1,2,8,16}, INV=0, IN=all zeros -> OUT=6363...63 (16 bytes), with latency 16, 8, 2 and 1 cycles respectively.
REQ-034 Hold OUT_READY=0 for 10 cycles in DONE -> OUT_VALID and OUT stay constant, IN_READY=0, and IN_VALID pulses are ignored; then OUT_READY=1 -> IDLE next cycle.
REQ-035 Assert RST two cycles after an accept with LANES=4 -> OUT=0, OUT_VALID=0, and IN_READY=1 immediately; no result emerges afterwards.
REQ-036 Issue back-to-back blocks with OUT_READY tied high, toggling INV per block -> each result matches the per-block mode, at a spacing of STEPS+2 cycles.
